// File: rtl/painterengine_gpu_reader_scheduler_pkg.sv
// Shared constants for the GPU reader scheduler: channel count, slot width,
// reader error codes and scheduler state encodings.
package gpu_reader_pkg;

  localparam int REQ_COUNT = 4;
  localparam int SLOT_W    = 32;

  // Reader-native error codes occupy 000..101; the abort code sits just above them.
  localparam logic [2:0] RD_ERR_FIRST = 3'b000;
  localparam logic [2:0] RD_ERR_LAST  = 3'b101;
  localparam logic [2:0] ERR_ABORT    = 3'b110;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef logic [SLOT_W-1:0] slot_t;

  function automatic logic [REQ_COUNT*SLOT_W-1:0] slot_place(input slot_t v, input logic [1:0] idx);
    logic [REQ_COUNT*SLOT_W-1:0] r;
    r = '0;
    r[{idx, 5'd0} +: SLOT_W] = v;
    return r;
  endfunction

endpackage

// File: rtl/painterengine_gpu_reader_scheduler_if.sv
// Requester and reader-control signals of the GPU reader scheduler.
interface painterengine_gpu_reader_scheduler_if;
  import gpu_reader_pkg::*;

  logic [REQ_COUNT-1:0]        i_wire_req_valid;
  logic [REQ_COUNT*SLOT_W-1:0] i_wire_req_address;
  logic [REQ_COUNT*SLOT_W-1:0] i_wire_req_length;
  logic                        i_wire_abort;
  logic [REQ_COUNT-1:0]        o_wire_req_ready;
  logic [REQ_COUNT-1:0]        o_wire_req_done;
  logic [REQ_COUNT-1:0]        o_wire_req_error;
  logic [2:0]                  o_wire_req_error_type;
  logic                        o_wire_busy;
  logic                        o_wire_reader_resetn;
  logic [REQ_COUNT-1:0]        o_wire_reader_router;
  logic [REQ_COUNT*SLOT_W-1:0] o_wire_reader_address;
  logic [REQ_COUNT*SLOT_W-1:0] o_wire_reader_length;
  logic                        i_wire_reader_done;
  logic                        i_wire_reader_error;
  logic [2:0]                  i_wire_reader_error_type;

  modport master (
    output i_wire_req_valid, i_wire_req_address, i_wire_req_length, i_wire_abort,
    output i_wire_reader_done, i_wire_reader_error, i_wire_reader_error_type,
    input  o_wire_req_ready, o_wire_req_done, o_wire_req_error, o_wire_req_error_type,
    input  o_wire_busy, o_wire_reader_resetn, o_wire_reader_router,
    input  o_wire_reader_address, o_wire_reader_length
  );

  modport slave (
    input  i_wire_req_valid, i_wire_req_address, i_wire_req_length, i_wire_abort,
    input  i_wire_reader_done, i_wire_reader_error, i_wire_reader_error_type,
    output o_wire_req_ready, o_wire_req_done, o_wire_req_error, o_wire_req_error_type,
    output o_wire_busy, o_wire_reader_resetn, o_wire_reader_router,
    output o_wire_reader_address, o_wire_reader_length
  );

endinterface

// File: rtl/painterengine_gpu_reader_scheduler_arbiter.sv
// Combinational round-robin arbiter: first requesting channel at or after ptr_i wins.
module painterengine_gpu_rr_arbiter
  import gpu_reader_pkg::*;
(
  input  logic [REQ_COUNT-1:0] req_i,
  input  logic [1:0]           ptr_i,
  output logic [REQ_COUNT-1:0] grant_o,
  output logic [1:0]           idx_o,
  output logic                 any_o
);

  logic [1:0] cand_s;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    idx_o  = 2'd0;
    any_o  = 1'b0;
    cand_s = 2'd0;
    for (int k = REQ_COUNT - 1; k >= 0; k--) begin
      cand_s = ptr_i + 2'(k);
      if (req_i[cand_s]) begin
        idx_o = cand_s;
        any_o = 1'b1;
      end else begin
        idx_o = idx_o;
      end
    end
    if (any_o) begin
      grant_o = 4'b0001 << idx_o;
    end else begin
      grant_o = 4'b0000;
    end
  end

endmodule

// File: rtl/painterengine_gpu_reader_scheduler.sv
// Time-shares the single GPU DMA reader between four requesters, re-arming the
// reader by pulsing its reset between jobs because its done/error are sticky.
module painterengine_gpu_reader_scheduler
  import gpu_reader_pkg::*;
#(
  parameter int unsigned RELEASE_CYCLES = 2
)(
  input logic                             i_wire_clock,
  input logic                             i_wire_resetn,
  painterengine_gpu_reader_scheduler_if.slave bus
);

  localparam logic [3:0] REL_INIT = 4'(RELEASE_CYCLES - 1);

  logic [1:0]                  state_q, state_d;
  logic [1:0]                  ptr_q, ptr_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [REQ_COUNT-1:0]        router_q, router_d;
  logic [REQ_COUNT*SLOT_W-1:0] addr_q, addr_d;
  logic [REQ_COUNT*SLOT_W-1:0] len_q, len_d;
  logic [REQ_COUNT-1:0]        ready_q, ready_d;
  logic [REQ_COUNT-1:0]        done_q, done_d;
  logic [REQ_COUNT-1:0]        error_q, error_d;
  logic [2:0]                  etype_q, etype_d;
  logic                        rrstn_q, rrstn_d;
  logic                        busy_q, busy_d;

  logic [REQ_COUNT-1:0] arb_grant_s;
  logic [1:0]           arb_idx_s;
  logic                 arb_any_s;

  painterengine_gpu_rr_arbiter u_arb (
    .req_i   (bus.i_wire_req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant_s),
    .idx_o   (arb_idx_s),
    .any_o   (arb_any_s)
  );

  // Next-state logic; pulses default low and the router stays latched through RUN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    router_d = router_q;
    addr_d  = addr_q;
    len_d   = len_q;
    ready_d = 4'b0000;
    done_d  = 4'b0000;
    error_d = 4'b0000;
    etype_d = 3'b000;
    rrstn_d = rrstn_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any_s) begin
          ready_d  = arb_grant_s;
          router_d = arb_grant_s;
          addr_d   = slot_place(bus.i_wire_req_address[{arb_idx_s, 5'd0} +: SLOT_W], arb_idx_s);
          len_d    = slot_place(bus.i_wire_req_length[{arb_idx_s, 5'd0} +: SLOT_W], arb_idx_s);
          ptr_d    = arb_idx_s + 2'd1;
          state_d  = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        rrstn_d = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.i_wire_abort || bus.i_wire_reader_error || bus.i_wire_reader_done) begin
          rrstn_d  = 1'b0;
          router_d = 4'b0000;
          addr_d   = '0;
          len_d    = '0;
          cnt_d    = REL_INIT;
          state_d  = ST_RELEASE;
          if (bus.i_wire_abort) begin
            error_d = router_q;
            etype_d = ERR_ABORT;
          end else if (bus.i_wire_reader_error) begin
            error_d = router_q;
            etype_d = bus.i_wire_reader_error_type;
          end else begin
            done_d = router_q;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 2'd0;
      cnt_q    <= 4'd0;
      router_q <= 4'b0000;
      addr_q   <= '0;
      len_q    <= '0;
      ready_q  <= 4'b0000;
      done_q   <= 4'b0000;
      error_q  <= 4'b0000;
      etype_q  <= 3'b000;
      rrstn_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      router_q <= router_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      error_q  <= error_d;
      etype_q  <= etype_d;
      rrstn_q  <= rrstn_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.o_wire_req_ready      = ready_q;
  assign bus.o_wire_req_done       = done_q;
  assign bus.o_wire_req_error      = error_q;
  assign bus.o_wire_req_error_type = etype_q;
  assign bus.o_wire_busy           = busy_q;
  assign bus.o_wire_reader_resetn  = rrstn_q;
  assign bus.o_wire_reader_router  = router_q;
  assign bus.o_wire_reader_address = addr_q;
  assign bus.o_wire_reader_length  = len_q;

endmodule

// File: tb/tb_painterengine_gpu_reader_scheduler.sv
// Directed bench for the GPU reader scheduler with hand-computed expectations.
module tb_painterengine_gpu_reader_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  painterengine_gpu_reader_scheduler_if bus();

  painterengine_gpu_reader_scheduler #(.RELEASE_CYCLES(2)) dut (
    .i_wire_clock  (clk),
    .i_wire_resetn (rst_n),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output logic [3:0] g);
    g = 4'b0000;
    for (int i = 0; i < 40 && g == 4'b0000; i++) begin
      tick();
      g = bus.o_wire_req_ready;
    end
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      ok = !bus.o_wire_busy;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_chk++; if ({bus.o_wire_req_ready, bus.o_wire_req_done, bus.o_wire_req_error, bus.o_wire_req_error_type,
                  bus.o_wire_busy, bus.o_wire_reader_resetn, bus.o_wire_reader_router} !== 21'd0)
      $display("FAIL reset_ctrl got %b exp 0", {bus.o_wire_req_ready, bus.o_wire_req_done, bus.o_wire_req_error,
               bus.o_wire_req_error_type, bus.o_wire_busy, bus.o_wire_reader_resetn, bus.o_wire_reader_router});
    else n_pass++;
    n_chk++; if ({bus.o_wire_reader_address, bus.o_wire_reader_length} !== 256'd0)
      $display("FAIL reset_bus got %h exp 0", {bus.o_wire_reader_address, bus.o_wire_reader_length}); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_chk++; if (bus.o_wire_busy !== 1'b0) $display("FAIL reset_idle_busy got %b exp 0", bus.o_wire_busy); else n_pass++;
  endtask

  task automatic test_single_done();
    int stray;
    bus.i_wire_req_valid   = 4'b0100;
    bus.i_wire_req_address = 128'h00000000_00001000_00000000_00000000;
    bus.i_wire_req_length  = 128'h00000000_00000010_00000000_00000000;
    tick();
    n_chk++; if (bus.o_wire_req_ready !== 4'b0100) $display("FAIL t1_ready got %b exp 0100", bus.o_wire_req_ready); else n_pass++;
    n_chk++; if (bus.o_wire_reader_router !== 4'b0100) $display("FAIL t1_router got %b exp 0100", bus.o_wire_reader_router); else n_pass++;
    n_chk++; if (bus.o_wire_reader_address !== 128'h00000000_00001000_00000000_00000000)
      $display("FAIL t1_addr got %h exp slot2=1000", bus.o_wire_reader_address); else n_pass++;
    n_chk++; if (bus.o_wire_reader_length !== 128'h00000000_00000010_00000000_00000000)
      $display("FAIL t1_len got %h exp slot2=10", bus.o_wire_reader_length); else n_pass++;
    n_chk++; if (bus.o_wire_reader_resetn !== 1'b0 || bus.o_wire_busy !== 1'b1)
      $display("FAIL t1_arm got rstn=%b busy=%b exp 0/1", bus.o_wire_reader_resetn, bus.o_wire_busy); else n_pass++;
    bus.i_wire_req_valid = 4'b0000;
    tick();
    n_chk++; if (bus.o_wire_reader_resetn !== 1'b1 || bus.o_wire_req_ready !== 4'b0000)
      $display("FAIL t1_run got rstn=%b ready=%b exp 1/0000", bus.o_wire_reader_resetn, bus.o_wire_req_ready); else n_pass++;
    stray = 0;
    for (int i = 0; i < 28; i++) begin
      tick();
      if ((bus.o_wire_req_done | bus.o_wire_req_error | bus.o_wire_req_ready) != 4'b0000) stray++;
    end
    bus.i_wire_reader_done = 1'b1;
    tick();
    n_chk++; if (bus.o_wire_req_done !== 4'b0100 || bus.o_wire_req_error !== 4'b0000)
      $display("FAIL t1_done got done=%b err=%b exp 0100/0000", bus.o_wire_req_done, bus.o_wire_req_error); else n_pass++;
    n_chk++; if (bus.o_wire_reader_resetn !== 1'b0 || bus.o_wire_reader_router !== 4'b0000 || bus.o_wire_reader_address !== 128'd0)
      $display("FAIL t1_release got rstn=%b router=%b exp 0/0000", bus.o_wire_reader_resetn, bus.o_wire_reader_router); else n_pass++;
    bus.i_wire_reader_done = 1'b0;
    tick();
    n_chk++; if (bus.o_wire_req_done !== 4'b0000 || bus.o_wire_reader_resetn !== 1'b0 || bus.o_wire_busy !== 1'b1)
      $display("FAIL t1_rel2 got done=%b rstn=%b busy=%b exp 0000/0/1", bus.o_wire_req_done, bus.o_wire_reader_resetn, bus.o_wire_busy);
    else n_pass++;
    tick();
    n_chk++; if (bus.o_wire_busy !== 1'b0 || bus.o_wire_reader_resetn !== 1'b0)
      $display("FAIL t1_idle got busy=%b rstn=%b exp 0/0", bus.o_wire_busy, bus.o_wire_reader_resetn); else n_pass++;
    n_chk++; if (stray !== 0) $display("FAIL t1_stray got %0d exp 0", stray); else n_pass++;
  endtask

  task automatic test_rr();
    logic [3:0] exp_g [5];
    logic [3:0] g;
    logic ok;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.i_wire_req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_ready(g);
      n_chk++; if (g !== exp_g[j]) $display("FAIL rr_grant%0d got %b exp %b", j, g, exp_g[j]); else n_pass++;
      tick();
      bus.i_wire_reader_done = 1'b1;
      tick();
      bus.i_wire_reader_done = 1'b0;
      n_chk++; if (bus.o_wire_req_done !== exp_g[j]) $display("FAIL rr_done%0d got %b exp %b", j, bus.o_wire_req_done, exp_g[j]); else n_pass++;
    end
    bus.i_wire_req_valid = 4'b0000;
    wait_idle(ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL rr_idle got %b exp 1", ok); else n_pass++;
  endtask

  task automatic test_err_done();
    logic [3:0] g;
    logic ok;
    bus.i_wire_req_valid = 4'b1000;
    wait_ready(g);
    bus.i_wire_req_valid = 4'b0000;
    n_chk++; if (g !== 4'b1000) $display("FAIL ed_grant got %b exp 1000", g); else n_pass++;
    tick();
    bus.i_wire_reader_error = 1'b1;
    bus.i_wire_reader_done = 1'b1;
    bus.i_wire_reader_error_type = 3'b011;
    tick();
    bus.i_wire_reader_error = 1'b0;
    bus.i_wire_reader_done = 1'b0;
    bus.i_wire_reader_error_type = 3'b000;
    n_chk++; if (bus.o_wire_req_error !== 4'b1000 || bus.o_wire_req_error_type !== 3'b011)
      $display("FAIL ed_error got err=%b type=%b exp 1000/011", bus.o_wire_req_error, bus.o_wire_req_error_type); else n_pass++;
    n_chk++; if (bus.o_wire_req_done !== 4'b0000) $display("FAIL ed_nodone got %b exp 0000", bus.o_wire_req_done); else n_pass++;
    wait_idle(ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL ed_idle got %b exp 1", ok); else n_pass++;
  endtask

  task automatic test_abort();
    logic [3:0] g;
    logic ok;
    bus.i_wire_req_valid = 4'b0010;
    wait_ready(g);
    bus.i_wire_req_valid = 4'b0000;
    n_chk++; if (g !== 4'b0010) $display("FAIL ab_grant got %b exp 0010", g); else n_pass++;
    for (int i = 0; i < 5; i++) tick();
    bus.i_wire_abort = 1'b1;
    tick();
    n_chk++; if (bus.o_wire_req_error !== 4'b0010 || bus.o_wire_req_error_type !== 3'b110)
      $display("FAIL ab_error got err=%b type=%b exp 0010/110", bus.o_wire_req_error, bus.o_wire_req_error_type); else n_pass++;
    n_chk++; if (bus.o_wire_reader_resetn !== 1'b0 || bus.o_wire_req_done !== 4'b0000)
      $display("FAIL ab_rstn got rstn=%b done=%b exp 0/0000", bus.o_wire_reader_resetn, bus.o_wire_req_done); else n_pass++;
    tick();
    n_chk++; if (bus.o_wire_req_error !== 4'b0000) $display("FAIL ab_release_ignored got %b exp 0000", bus.o_wire_req_error); else n_pass++;
    bus.i_wire_abort = 1'b0;
    wait_idle(ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL ab_idle got %b exp 1", ok); else n_pass++;
  endtask

  task automatic test_midrun_reset();
    logic [3:0] g;
    logic ok;
    bus.i_wire_req_valid = 4'b0100;
    wait_ready(g);
    bus.i_wire_req_valid = 4'b0000;
    n_chk++; if (g !== 4'b0100) $display("FAIL mr_grant got %b exp 0100", g); else n_pass++;
    tick();
    n_chk++; if (bus.o_wire_reader_resetn !== 1'b1) $display("FAIL mr_run got %b exp 1", bus.o_wire_reader_resetn); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({bus.o_wire_req_ready, bus.o_wire_req_done, bus.o_wire_req_error, bus.o_wire_busy,
                  bus.o_wire_reader_resetn, bus.o_wire_reader_router, bus.o_wire_reader_address, bus.o_wire_reader_length} !== 274'd0)
      $display("FAIL mr_clear got rstn=%b busy=%b router=%b exp all 0", bus.o_wire_reader_resetn, bus.o_wire_busy, bus.o_wire_reader_router);
    else n_pass++;
    bus.i_wire_reader_done = 1'b1;
    tick(); tick();
    n_chk++; if ((bus.o_wire_req_done | bus.o_wire_req_error | bus.o_wire_req_ready) !== 4'b0000)
      $display("FAIL mr_nopulse got %b exp 0000", bus.o_wire_req_done | bus.o_wire_req_error | bus.o_wire_req_ready); else n_pass++;
    bus.i_wire_reader_done = 1'b0;
    rst_n = 1'b1;
    bus.i_wire_req_valid = 4'b1111;
    wait_ready(g);
    bus.i_wire_req_valid = 4'b0000;
    n_chk++; if (g !== 4'b0001) $display("FAIL mr_ptr_reset got %b exp 0001", g); else n_pass++;
    tick();
    bus.i_wire_reader_done = 1'b1;
    tick();
    bus.i_wire_reader_done = 1'b0;
    n_chk++; if (bus.o_wire_req_done !== 4'b0001) $display("FAIL mr_done got %b exp 0001", bus.o_wire_req_done); else n_pass++;
    wait_idle(ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL mr_idle got %b exp 1", ok); else n_pass++;
  endtask

  task automatic test_addr_hold();
    logic [3:0] g;
    logic ok;
    bus.i_wire_req_valid   = 4'b0010;
    bus.i_wire_req_address = 128'h00000000_00000000_AAAA0000_00000000;
    bus.i_wire_req_length  = 128'h00000000_00000000_00000008_00000000;
    wait_ready(g);
    bus.i_wire_req_valid   = 4'b0000;
    n_chk++; if (g !== 4'b0010) $display("FAIL ah_grant got %b exp 0010", g); else n_pass++;
    bus.i_wire_req_address = 128'h00000000_00000000_BBBB0000_00000000;
    bus.i_wire_req_length  = 128'h00000000_00000000_00000063_00000000;
    for (int i = 0; i < 4; i++) tick();
    n_chk++; if (bus.o_wire_reader_address !== 128'h00000000_00000000_AAAA0000_00000000)
      $display("FAIL ah_addr got %h exp slot1=AAAA0000", bus.o_wire_reader_address); else n_pass++;
    n_chk++; if (bus.o_wire_reader_length !== 128'h00000000_00000000_00000008_00000000)
      $display("FAIL ah_len got %h exp slot1=8", bus.o_wire_reader_length); else n_pass++;
    bus.i_wire_reader_done = 1'b1;
    tick();
    bus.i_wire_reader_done = 1'b0;
    n_chk++; if (bus.o_wire_req_done !== 4'b0010 || bus.o_wire_reader_address !== 128'd0)
      $display("FAIL ah_done got done=%b addr=%h exp 0010/0", bus.o_wire_req_done, bus.o_wire_reader_address); else n_pass++;
    wait_idle(ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL ah_idle got %b exp 1", ok); else n_pass++;
  endtask

  initial begin
    bus.i_wire_req_valid         = 4'b0000;
    bus.i_wire_req_address       = 128'd0;
    bus.i_wire_req_length        = 128'd0;
    bus.i_wire_abort             = 1'b0;
    bus.i_wire_reader_done       = 1'b0;
    bus.i_wire_reader_error      = 1'b0;
    bus.i_wire_reader_error_type = 3'b000;
    test_reset();
    test_rr();
    test_single_done();
    test_err_done();
    test_abort();
    test_midrun_reset();
    test_addr_hold();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
